// File: rtl/shift_reg_universal.sv
// Purpose : universal shift register (hold / shift right / shift left / parallel load)
//           with a per-frame step counter and a frame-done pulse; SERDES building block.
// Latency : one cycle for every register update; pout/sout_r/sout_l are direct slices of
//           the register, so they change right after the updating clock edge.
// Backpressure: none; enb=0 freezes all state and clears frame_done.
// Ports   : clk, rst (sync, active-high), enb, mode[1:0] (00 hold, 01 right, 10 left,
//           11 load), sin_r/sin_l [SW] serial in, pdata [DW] load data, pout [DW] contents,
//           sout_r = low SW bits, sout_l = high SW bits, cnt [CW] steps since load
//           (saturates at NSTEP), frame_done one-cycle pulse when cnt reaches NSTEP.
// Option  : define SHIFT_ROTATE_EN to add input rot; with rot=1 shifts become rotates.
module shift_reg_universal #(
   parameter  int DW    = 8,
   parameter  int SW    = 1,
   localparam int NSTEP = DW / SW,
   localparam int CW    = $clog2(NSTEP + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic [1:0]    mode,
   input  logic [SW-1:0] sin_r,
   input  logic [SW-1:0] sin_l,
   input  logic [DW-1:0] pdata,
`ifdef SHIFT_ROTATE_EN
   input  logic          rot,
`endif
   output logic [DW-1:0] pout,
   output logic [SW-1:0] sout_r,
   output logic [SW-1:0] sout_l,
   output logic [CW-1:0] cnt,
   output logic          frame_done
);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Refuse to build a register whose width is not a whole number of lanes.
   if ((SW < 1) || (SW > DW) || ((DW % SW) != 0)) begin : g_bad_cfg
      $error("shift_reg_universal: DW (%0d) must be a non-zero multiple of SW (%0d)", DW, SW);
   end

   logic [DW-1:0] rgstr;
   logic [DW-1:0] rgstr_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          done_nxt;
   logic [SW-1:0] ins_r;
   logic [SW-1:0] ins_l;
   logic [DW-1:0] shr_val;
   logic [DW-1:0] shl_val;
   logic          cnt_sat;
   logic          cnt_last;

`ifdef SHIFT_ROTATE_EN
   // Rotation feeds the lane that is leaving back in at the opposite end.
   assign ins_r = rot ? rgstr[SW-1:0]     : sin_r;
   assign ins_l = rot ? rgstr[DW-1:DW-SW] : sin_l;
`else
   assign ins_r = sin_r;
   assign ins_l = sin_l;
`endif

   // A single-lane register has no bits to keep on a shift; the lane replaces the word.
   if (SW == DW) begin : g_full_lane
      assign shr_val = ins_r;
      assign shl_val = ins_l;
   end else begin : g_part_lane
      assign shr_val = {ins_r, rgstr[DW-1:SW]};
      assign shl_val = {rgstr[DW-SW-1:0], ins_l};
   end

   assign cnt_sat  = (cnt == CW'(NSTEP));
   assign cnt_last = (cnt == CW'(NSTEP - 1));

   always_comb begin
      rgstr_nxt = rgstr;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      if (enb) begin
         case (mode)
            MODE_SHR, MODE_SHL: begin
               rgstr_nxt = (mode == MODE_SHR) ? shr_val : shl_val;
               if (!cnt_sat) begin
                  cnt_nxt = cnt + 1'b1;
               end
               // Only the step that reaches NSTEP pulses; saturated steps stay quiet.
               done_nxt = cnt_last;
            end
            MODE_LOAD: begin
               rgstr_nxt = pdata;
               cnt_nxt   = '0;
            end
            MODE_HOLD: begin
               rgstr_nxt = rgstr;
            end
            default: begin
               rgstr_nxt = rgstr;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgstr      <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         rgstr      <= rgstr_nxt;
         cnt        <= cnt_nxt;
         frame_done <= done_nxt;
      end
   end

   assign pout   = rgstr;
   assign sout_r = rgstr[SW-1:0];
   assign sout_l = rgstr[DW-1:DW-SW];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Purpose : directed bench for shift_reg_universal; DW=8/SW=1 main instance checked
//           against a scoreboard model, DW=8/SW=2 instance checked for left-shift packing.
// Latency : expectations are taken 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_shift_reg_universal;

   logic       clk;
   logic       rst;
   logic       enb;
   logic [1:0] mode;
   logic       sin_r;
   logic       sin_l;
   logic [7:0] pdata;
   logic [7:0] pout;
   logic       sout_r;
   logic       sout_l;
   logic [3:0] cnt;
   logic       frame_done;
`ifdef SHIFT_ROTATE_EN
   logic       rot;
`endif

   logic [1:0] b_sin_r;
   logic [1:0] b_sin_l;
   logic [7:0] b_pout;
   logic [1:0] b_sout_r;
   logic [1:0] b_sout_l;
   logic [2:0] b_cnt;
   logic       b_frame_done;

   int errors = 0;
   int checks = 0;
   int pulses;

   typedef struct {
      logic [7:0] pout;
      int         cnt;
      logic       fd;
   } exp_t;
   exp_t sbq[$];

   // Reference state for the SW=1 instance.
   logic [7:0] m_reg;
   int         m_cnt;
   logic       m_fd;

   shift_reg_universal #(.DW(8), .SW(1)) dut (
      .clk(clk), .rst(rst), .enb(enb), .mode(mode),
      .sin_r(sin_r), .sin_l(sin_l), .pdata(pdata),
`ifdef SHIFT_ROTATE_EN
      .rot(rot),
`endif
      .pout(pout), .sout_r(sout_r), .sout_l(sout_l),
      .cnt(cnt), .frame_done(frame_done)
   );

   shift_reg_universal #(.DW(8), .SW(2)) dut_b (
      .clk(clk), .rst(rst), .enb(enb), .mode(mode),
      .sin_r(b_sin_r), .sin_l(b_sin_l), .pdata(pdata),
`ifdef SHIFT_ROTATE_EN
      .rot(rot),
`endif
      .pout(b_pout), .sout_r(b_sout_r), .sout_l(b_sout_l),
      .cnt(b_cnt), .frame_done(b_frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the model's post-edge expectation, clock once, pop and compare.
   task automatic tick(input string tag);
      exp_t e;
      logic sr;
      logic sl;
      sr = sin_r;
      sl = sin_l;
`ifdef SHIFT_ROTATE_EN
      if (rot) begin
         sr = m_reg[0];
         sl = m_reg[7];
      end
`endif
      if (rst) begin
         m_reg = 8'h00;
         m_cnt = 0;
         m_fd  = 1'b0;
      end else if (!enb) begin
         m_fd = 1'b0;
      end else begin
         m_fd = 1'b0;
         if (mode == 2'b01 || mode == 2'b10) begin
            m_reg = (mode == 2'b01) ? {sr, m_reg[7:1]} : {m_reg[6:0], sl};
            if (m_cnt == 7) m_fd = 1'b1;
            if (m_cnt < 8) m_cnt = m_cnt + 1;
         end else if (mode == 2'b11) begin
            m_reg = pdata;
            m_cnt = 0;
         end
      end
      e.pout = m_reg;
      e.cnt  = m_cnt;
      e.fd   = m_fd;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, ".pout"},   32'(pout),       32'(e.pout));
      chk({tag, ".cnt"},    32'(cnt),        32'(e.cnt));
      chk({tag, ".fd"},     32'(frame_done), 32'(e.fd));
      chk({tag, ".sout_r"}, 32'(sout_r),     32'(e.pout[0]));
      chk({tag, ".sout_l"}, 32'(sout_l),     32'(e.pout[7]));
      pulses += int'(frame_done);
   endtask

   logic [7:0] seq_a5;

   initial begin
      rst = 1'b1; enb = 1'b1; mode = 2'b11; pdata = 8'hFF;
      sin_r = 1'b0; sin_l = 1'b0; b_sin_r = 2'b00; b_sin_l = 2'b00;
`ifdef SHIFT_ROTATE_EN
      rot = 1'b0;
`endif
      m_reg = 8'h00; m_cnt = 0; m_fd = 1'b0; pulses = 0;

      // 1: reset wins over enable and load
      tick("rst1");
      tick("rst2");
      chk("rst.pout_const", 32'(pout), 32'h0);
      chk("rst.b_pout", 32'(b_pout), 32'h0);
      chk("rst.b_cnt", 32'(b_cnt), 32'h0);

      // 2: load A5, shift out LSB first, then one saturated shift
      rst = 1'b0; mode = 2'b11; pdata = 8'hA5;
      tick("ld_a5");
      seq_a5 = 8'b1010_0101;
      mode = 2'b01; sin_r = 1'b0; pulses = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a5.sout_r%0d", i), 32'(sout_r), 32'(seq_a5[7 - i]));
         tick($sformatf("a5.shr%0d", i));
      end
      chk("a5.pout_empty", 32'(pout), 32'h00);
      chk("a5.fd_after8", 32'(frame_done), 32'h1);
      tick("a5.shr9");
      chk("a5.cnt_sat", 32'(cnt), 32'd8);
      chk("a5.one_pulse", 32'(pulses), 32'd1);

      // 3: SW=2 left shifts pack 11,10,01,00 into E4
      mode = 2'b11; pdata = 8'h00;
      tick("b.ld");
      mode = 2'b10;
      for (int i = 0; i < 4; i++) begin
         b_sin_l = 2'(3 - i);
         tick($sformatf("b.shl%0d", i));
         chk($sformatf("b.fd%0d", i), 32'(b_frame_done), 32'(i == 3));
      end
      chk("b.pout", 32'(b_pout), 32'hE4);
      chk("b.cnt", 32'(b_cnt), 32'd4);

      // 4: enable gap freezes the frame mid-way
      mode = 2'b11; pdata = 8'h3C;
      tick("en.ld");
      mode = 2'b01; sin_r = 1'b1; pulses = 0;
      for (int i = 0; i < 3; i++) tick($sformatf("en.shr%0d", i));
      enb = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick($sformatf("en.off%0d", i));
         chk($sformatf("en.frozen%0d", i), 32'(pout), 32'hE7);
         chk($sformatf("en.cnt%0d", i), 32'(cnt), 32'd3);
      end
      enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick($sformatf("en.re%0d", i));
         chk($sformatf("en.fd%0d", i), 32'(frame_done), 32'(i == 4));
      end
      chk("en.pulses", 32'(pulses), 32'd1);

      // 5: reset aborts a frame; next frame counts from zero without a load
      mode = 2'b11; pdata = 8'h5A;
      tick("ab.ld");
      mode = 2'b01; sin_r = 1'b0; pulses = 0;
      for (int i = 0; i < 4; i++) tick($sformatf("ab.shr%0d", i));
      rst = 1'b1;
      tick("ab.rst");
      chk("ab.cnt0", 32'(cnt), 32'd0);
      rst = 1'b0; mode = 2'b10; sin_l = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick($sformatf("ab.post%0d", i));
         chk($sformatf("ab.fd%0d", i), 32'(frame_done), 32'(i == 7));
      end
      chk("ab.pout_ff", 32'(pout), 32'hFF);
      chk("ab.pulses", 32'(pulses), 32'd1);

`ifdef SHIFT_ROTATE_EN
      // 6: rotation
      mode = 2'b11; pdata = 8'h81;
      tick("rot.ld");
      rot = 1'b1; mode = 2'b01;
      tick("rot.one");
      chk("rot.c0", 32'(pout), 32'hC0);
      rot = 1'b0; mode = 2'b11;
      tick("rot.ld2");
      rot = 1'b1; mode = 2'b01; sin_r = 1'b0; pulses = 0;
      for (int i = 0; i < 8; i++) tick($sformatf("rot.r%0d", i));
      chk("rot.back", 32'(pout), 32'h81);
      chk("rot.pulses", 32'(pulses), 32'd1);
      rot = 1'b0;
`endif

      // Hold keeps everything and clears the pulse
      mode = 2'b00;
      tick("hold");
      chk("hold.fd", 32'(frame_done), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register, generalising the single-bit, right-only SISO register.
- Shift width is configurable.
- Supports right shift, left shift, parallel load and hold, with both serial ends and the parallel word visible.
- A step counter and a frame-done pulse let a controller know when a loaded word has been fully shifted out.
- Used as the serialiser/deserialiser building block for the team's serial links.

Parameters:
DW, 8, register width in bits; must be a multiple of SW.
SW, 1, bits moved per shift step (serial lane width); 1 <= SW <= DW.
NSTEP, DW/SW (derived localparam), shift steps per frame.
CW, $clog2(NSTEP+1) (derived localparam), step counter width.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
enb  input  1  clock enable; no state change when low.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
sin_r  input  SW  serial data entering at the MSB end on right shift.
sin_l  input  SW  serial data entering at the LSB end on left shift.
pdata  input  DW  parallel load data.
pout  output  DW  register contents.
sout_r  output  SW  rgstr[SW-1:0]; bits leaving on right shift.
sout_l  output  SW  rgstr[DW-1:DW-SW]; bits leaving on left shift.
cnt  output  CW  shift steps taken since the last load; saturates at NSTEP.
frame_done  output  1  one-cycle pulse when cnt reaches NSTEP.

Behaviour:
- Reset
  - The rising edge of clk with rst=1 sets rgstr=0, cnt=0 and frame_done=0.
  - rst has priority over enb and mode.
  - A reset in the middle of a frame aborts it; no frame_done is produced.
- Register update (all registered, one-cycle latency, applied only when enb=1)
  - 00 (hold): rgstr unchanged, cnt unchanged.
  - 01 (shift right): rgstr <= {sin_r, rgstr[DW-1:SW]}.
  - 10 (shift left): rgstr <= {rgstr[DW-SW-1:0], sin_l}.
  - 11 (load): rgstr <= pdata and cnt <= 0.
  - When SW == DW, a shift replaces the whole word with sin_r or sin_l.
- Step counter
  - Each enabled shift (01 or 10) does cnt <= cnt+1 if cnt < NSTEP; otherwise cnt holds at NSTEP.
  - Mixing directions within a frame is legal; every step counts.
- frame_done
  - Registered; it is 1 in exactly the cycle after the enabled shift that moves cnt from NSTEP-1 to NSTEP. Otherwise it is 0.
  - No re-pulse while cnt is saturated; the next pulse requires a load first.
  - With enb=0, frame_done returns to 0 and cnt holds.
  - If a load and the completing shift are requested in the same cycle, they are mutually exclusive by mode encoding, so no conflict can arise.
- Outputs
  - pout, sout_r and sout_l are combinational slices of rgstr, so they are valid in the same cycle the register updates.
  - All outputs are 0 after reset.
- Elaboration must fail (assertion or $error) if DW % SW != 0 or SW > DW.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- When defined:
  - Adds input port rot (1 bit).
  - When rot=1, right shift inserts rgstr[SW-1:0] at the MSB end instead of sin_r, and left shift inserts rgstr[DW-1:DW-SW] at the LSB end instead of sin_l.
  - Rotation steps count toward cnt and frame_done exactly like shifts.
- When not defined:
  - The rot port does not exist.
  - Shifts always take sin_r/sin_l.

Test Plan:
1. DW=8, SW=1: rst=1 for 2 cycles with enb=1, mode=11, pdata=8'hFF -> pout=0, cnt=0, frame_done=0 throughout reset.
2. DW=8, SW=1: load 8'hA5, then 8 right shifts with sin_r=0 -> sout_r sequence before each edge is 1,0,1,0,0,1,0,1; pout=0 after the 8th shift; frame_done=1 only in the cycle after the 8th shift; cnt=8 and stays 8 on a 9th shift, with no second pulse.
3. DW=8, SW=2: load 8'h00, then 4 left shifts with sin_l=2'b11,2'b10,2'b01,2'b00 -> pout=8'hE4; frame_done pulses after the 4th shift.
4. Load 8'h3C, 3 shifts, then enb=0 for 5 cycles with mode=01 -> pout and cnt frozen (cnt=3), frame_done=0; re-enabling for 5 more shifts gives a pulse after the 5th of those (8 total).
5. Load, 4 shifts, then rst=1 for one cycle, then 8 shifts without a load -> cnt=0 after reset, frame_done pulses after the 8th post-reset shift; no pulse during the aborted frame.
6. With SHIFT_ROTATE_EN, DW=8, SW=1: load 8'h81, rot=1, 1 right shift -> pout=8'hC0; 8 rotations from the 8'h81 load -> pout=8'h81 and frame_done pulses once.
